// File: rtl/sha256_host.sv
// Feeds one buffered 64-byte block to the sha256 core on its sampling cycles and collects the 16 digest words.
// Digest valid 115 cycles after the last input byte; out_ready low holds the digest and blocks new input.
module sha256_host #(
  parameter int FEED_LEN  = 64,
  parameter int CAP_FIRST = 98,
  parameter int CAP_LAST  = 113
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         core_load,
  output logic [7:0]   core_msg,
  input  logic [15:0]  core_hash
);

  typedef enum logic [1:0] {FILL, LOAD, RUN, OUT} state_e;

  state_e       state_q, state_d;
  logic [7:0]   blk_q [FEED_LEN];
  logic [7:0]   blk_d [FEED_LEN];
  logic [5:0]   idx_q, idx_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [255:0] digest_q, digest_d;

  logic         in_feed;
  logic         in_cap;
  logic [5:0]   feed_idx;
  logic [3:0]   cap_word;

  // cnt counts cycles since LOAD, so cnt-1 is the byte the core samples now
  assign feed_idx = 6'(cnt_q - 7'd1);
  assign cap_word = 4'(cnt_q - 7'(CAP_FIRST));
  assign in_feed  = (state_q == RUN) && (cnt_q >= 7'd1) && (cnt_q <= 7'(FEED_LEN));
  assign in_cap   = (state_q == RUN) && (cnt_q >= 7'(CAP_FIRST)) && (cnt_q <= 7'(CAP_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (in_valid && (idx_q == 6'(FEED_LEN - 1))) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (cnt_q == 7'(CAP_LAST)) state_d = OUT;
      OUT:  if (out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    core_load = (state_q == LOAD);
    out_valid = (state_q == OUT);
    core_msg  = in_feed ? blk_q[feed_idx] : 8'h00;
    digest    = digest_q;
  end

  always_comb begin
    blk_d    = blk_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    digest_d = digest_q;
    if ((state_q == FILL) && in_valid) begin
      blk_d[idx_q] = in_data;
      idx_d        = idx_q + 6'd1;
    end
    if (state_q == LOAD) begin
      cnt_d = 7'd1;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 7'd1;
    end else if ((state_q == OUT) && out_ready) begin
      cnt_d = 7'd0;
    end
    if (in_cap) begin
      for (int w = 0; w < 16; w++) begin
        if (cap_word == 4'(w)) digest_d[255 - 16*w -: 16] = core_hash;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FEED_LEN; i++) blk_q[i] <= 8'h00;
      idx_q    <= 6'd0;
      cnt_q    <= 7'd0;
      digest_q <= 256'd0;
    end else begin
      blk_q    <= blk_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      digest_q <= digest_d;
    end
  end

endmodule

// File: tb/tb_sha256_host.sv
// Bench for sha256_host: a behavioural sha256 core stand-in plus a timeline model checked every cycle.
module tb_sha256_host;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, core_load;
  logic [7:0]   in_data, core_msg;
  logic [255:0] digest;
  logic [15:0]  core_hash;

  int n_cmp = 0;
  int n_err = 0;
  int tcyc = 0;
  int load_cnt = 0;

  logic [511:0] blk_empty, blk_abc;
  logic [255:0] lit_empty, lit_abc;

  sha256_host dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .digest(digest),
    .core_load(core_load), .core_msg(core_msg), .core_hash(core_hash)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tcyc <= tcyc + 1;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 compression of a single pre-padded block from the standard initial hash
  function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] h0 [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    h0 = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = h0[0]; b = h0[1]; c = h0[2]; d = h0[3];
    e = h0[4]; f = h0[5]; g = h0[6]; h = h0[7];
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {h0[0] + a, h0[1] + b, h0[2] + c, h0[3] + d,
            h0[4] + e, h0[5] + f, h0[6] + g, h0[7] + h};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Core stand-in: records bytes on its sampling cycles, hashes them, returns words at 98..113
  int           c_t = -1;
  logic [7:0]   c_bytes [64];
  logic [511:0] c_pk;
  logic [255:0] c_dig;

  always @(negedge clk) begin
    if (!rst_n) begin
      c_t       = -1;
      core_hash = 16'h0000;
    end else begin
      if (core_load) c_t = 0;
      else if (c_t >= 0 && c_t < 1000) c_t++;
      if (c_t >= 1 && c_t <= 64) c_bytes[c_t-1] = core_msg;
      if (c_t == 64) begin
        for (int k = 0; k < 64; k++) c_pk[511 - 8*k -: 8] = c_bytes[k];
        c_dig = sha256_blk(c_pk);
      end
      if (c_t >= 98 && c_t <= 113) core_hash = c_dig[255 - 16*(c_t-98) -: 16];
      else core_hash = 16'($urandom);
    end
  end

  always @(negedge clk) if (rst_n && core_load) load_cnt++;

  // Timeline model: t = cycles since the 64th byte was accepted
  bit           m_busy = 0;
  int           m_t = 0;
  logic [7:0]   m_q [$];
  logic [7:0]   m_blk [64];
  logic [511:0] m_pk;
  logic [255:0] m_dig;
  logic         e_rdy, e_load, e_ov;
  logic [7:0]   e_msg;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0;
      m_t    = 0;
      m_q.delete();
    end else begin
      e_rdy  = !m_busy;
      e_load = m_busy && (m_t == 1);
      e_msg  = (m_busy && m_t >= 2 && m_t <= 65) ? m_blk[m_t-2] : 8'h00;
      e_ov   = m_busy && (m_t >= 115);
      chk("in_ready", 256'(in_ready), 256'(e_rdy));
      chk("core_load", 256'(core_load), 256'(e_load));
      chk("core_msg", 256'(core_msg), 256'(e_msg));
      chk("out_valid", 256'(out_valid), 256'(e_ov));
      if (e_ov) chk("digest", digest, m_dig);
      if (m_busy) begin
        if (e_ov && out_ready) begin
          m_busy = 0;
          m_q.delete();
        end else begin
          m_t++;
        end
      end else if (in_valid) begin
        m_q.push_back(in_data);
        if (m_q.size() == 64) begin
          for (int k = 0; k < 64; k++) begin
            m_blk[k] = m_q[k];
            m_pk[511 - 8*k -: 8] = m_q[k];
          end
          m_dig  = sha256_blk(m_pk);
          m_busy = 1;
          m_t    = 1;
        end
      end
    end
  end

  task automatic send_block(input logic [511:0] blk, input bit gaps, output int acc_cyc);
    bit done;
    int g;
    acc_cyc = 0;
    for (int k = 0; k < 64; k++) begin
      if (gaps) begin
        g = int'($urandom_range(0, 3));
        repeat (g) begin
          in_valid = 1'b0;
          in_data  = 8'h00;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = blk[511 - 8*k -: 8];
      done = 0;
      for (int w = 0; w < 500 && !done; w++) begin
        @(negedge clk);
        done    = in_ready;
        acc_cyc = tcyc;
        @(posedge clk); #1;
      end
      if (!done) begin
        chk("send_timeout", 256'(0), 256'(1));
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic run_block(input logic [511:0] blk, input bit gaps, input int hold,
                           input logic [255:0] lit, input string nm);
    int  acc_cyc, base;
    bit  seen;
    out_ready = (hold == 0);
    base = load_cnt;
    send_block(blk, gaps, acc_cyc);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk({nm, "_out_valid_seen"}, 256'(seen), 256'(1));
    if (seen) begin
      chk({nm, "_latency"}, 256'(tcyc - acc_cyc), 256'(115));
      chk({nm, "_digest"}, digest, lit);
      chk({nm, "_load_pulses"}, 256'(load_cnt - base), 256'(1));
      if (hold > 0) begin
        for (int i = 0; i < hold; i++) begin
          @(posedge clk); #1;
          in_valid = 1'b1;
          in_data  = 8'ha5;
        end
        @(negedge clk);
        chk({nm, "_held_digest"}, digest, lit);
        chk({nm, "_held_in_ready"}, 256'(in_ready), 256'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
      end else begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk({nm, "_in_ready_after_hs"}, 256'(in_ready), 256'(1));
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_run();
    int acc_cyc;
    bit hit;
    out_ready = 1'b1;
    send_block(blk_abc, 1'b0, acc_cyc);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk); #1;
      hit = m_busy && (m_t == 71);
    end
    chk("rst_reached_cnt70", 256'(hit), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", 256'(out_valid), 256'(0));
    chk("rst_async_core_load", 256'(core_load), 256'(0));
    chk("rst_async_core_msg", 256'(core_msg), 256'(0));
    chk("rst_async_digest", digest, 256'd0);
    @(negedge clk);
    chk("rst_hold_out_valid", 256'(out_valid), 256'(0));
    chk("rst_hold_digest", digest, 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    blk_empty = {8'h80, 504'h0};
    blk_abc   = {32'h61626380, 416'h0, 64'h18};
    lit_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    lit_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    chk("model_empty", sha256_blk(blk_empty), lit_empty);
    chk("model_abc", sha256_blk(blk_abc), lit_abc);

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_core_load", 256'(core_load), 256'(0));
    chk("reset_core_msg", 256'(core_msg), 256'(0));
    chk("reset_digest", digest, 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_block(blk_empty, 1'b0, 0, lit_empty, "empty");
    run_block(blk_abc, 1'b1, 0, lit_abc, "abc_gaps");
    run_block(blk_abc, 1'b0, 50, lit_abc, "abc_hold");
    reset_mid_run();
    run_block(blk_abc, 1'b1, 0, lit_abc, "abc_after_rst");
    run_block(blk_empty, 1'b0, 0, lit_empty, "empty_after_abc");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule
